// File: rtl/updown_counter.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate behaviour at the range ends.
// The count, wrap and sat outputs are registered. The terminal-count flag tc is combinational.
module updown_counter #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 255,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rb,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             at_max, at_zero;

    // Ripple half-adder chain with a constant carry-in of one.
    function automatic logic [WIDTH-1:0] inc_f(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] s;
        logic             c;
        s[0] = ~a[0];
        c    = a[0];
        for (int i = 1; i < WIDTH; i++) begin
            s[i] = a[i] ^ c;
            c    = a[i] & c;
        end
        return s;
    endfunction

    // Half-subtractor chain: the borrow continues while the lower bits are zero.
    function automatic logic [WIDTH-1:0] dec_f(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] s;
        logic             b;
        s[0] = ~a[0];
        b    = ~a[0];
        for (int i = 1; i < WIDTH; i++) begin
            s[i] = a[i] ^ b;
            b    = ~a[i] & b;
        end
        return s;
    endfunction

    assign at_max  = (count_q == MAX_W);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    count_d = inc_f(count_q);
                end else if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = dec_f(count_q);
                end else if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    count_d = MAX_W;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    // While reset holds count_q at zero, tc follows the live inputs against a count of zero.
    assign tc    = en & (up ? at_max : at_zero);
    assign count = count_q;
    assign wrap  = wrap_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: five parameterisations share one set of stimulus inputs.
module tb_updown_counter;

    logic       clk, rb, clr, load, en, up;
    logic [7:0] load_val;

    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic [3:0] cnt_e;
    logic       tc_a, tc_b, tc_c, tc_d, tc_e;
    logic       wrap_a, wrap_b, wrap_c, wrap_d, wrap_e;
    logic       sat_a, sat_b, sat_c, sat_d, sat_e;

    int checks = 0;
    int errors = 0;

    updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_a (
        .clk(clk), .rb(rb), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .sat(sat_a));
    updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) u_b (
        .clk(clk), .rb(rb), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .sat(sat_b));
    updown_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) u_c (
        .clk(clk), .rb(rb), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .count(cnt_c), .tc(tc_c), .wrap(wrap_c), .sat(sat_c));
    updown_counter #(.WIDTH(8), .MAX_VAL(99), .SATURATE(1'b0)) u_d (
        .clk(clk), .rb(rb), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .count(cnt_d), .tc(tc_d), .wrap(wrap_d), .sat(sat_d));
    updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) u_e (
        .clk(clk), .rb(rb), .clr(clr), .load(load), .load_val(load_val[3:0]), .en(en), .up(up),
        .count(cnt_e), .tc(tc_e), .wrap(wrap_e), .sat(sat_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rb = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0; en = 1'b1; up = 1'b0;
        #2;
        checks++;
        if ({cnt_a, cnt_b, cnt_c, cnt_d, cnt_e} !== 36'd0) begin
            errors++; $display("FAIL reset_count: got %h expected 0", {cnt_a, cnt_b, cnt_c, cnt_d, cnt_e});
        end
        checks++;
        if ({wrap_a, wrap_b, wrap_c, wrap_d, wrap_e, sat_a, sat_b, sat_c, sat_d, sat_e} !== 10'd0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0",
                {wrap_a, wrap_b, wrap_c, wrap_d, wrap_e, sat_a, sat_b, sat_c, sat_d, sat_e});
        end
        checks++;
        if ({tc_a, tc_b, tc_c, tc_d, tc_e} !== 5'b11111) begin
            errors++; $display("FAIL reset_tc_down: got %b expected 11111", {tc_a, tc_b, tc_c, tc_d, tc_e});
        end
        up = 1'b1;
        #1;
        checks++;
        if ({tc_a, tc_b, tc_c, tc_d, tc_e} !== 5'b00000) begin
            errors++; $display("FAIL reset_tc_up: got %b expected 00000", {tc_a, tc_b, tc_c, tc_d, tc_e});
        end
        tick();
        tick();
        checks++;
        if (cnt_a !== 8'd0) begin
            errors++; $display("FAIL reset_held: got %0d expected 0", cnt_a);
        end
        en = 1'b0;
        @(negedge clk);
        rb = 1'b1;
    endtask

    task automatic test_wrap_up();
        en = 1'b1; up = 1'b1;
        #1;
        checks++;
        if (tc_a !== 1'b0) begin
            errors++; $display("FAIL up_tc_start: got %b expected 0", tc_a);
        end
        for (int i = 1; i <= 260; i++) begin
            tick();
            checks++;
            if (cnt_a !== 8'(i % 256)) begin
                errors++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, cnt_a, i % 256);
            end
            checks++;
            if (wrap_a !== (i == 256)) begin
                errors++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap_a, i == 256);
            end
            checks++;
            if (tc_a !== ((i % 256) == 255)) begin
                errors++; $display("FAIL up_tc[%0d]: got %b expected %b", i, tc_a, (i % 256) == 255);
            end
        end
    endtask

    task automatic test_wrap_down();
        clr = 1'b1; en = 1'b0;
        tick();
        clr = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        checks++;
        if (cnt_b !== 8'd0 || tc_b !== 1'b1) begin
            errors++; $display("FAIL down_start: got count %0d tc %b expected count 0 tc 1", cnt_b, tc_b);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (cnt_b !== 8'((10 - k % 10) % 10)) begin
                errors++; $display("FAIL down_count[%0d]: got %0d expected %0d", k, cnt_b, (10 - k % 10) % 10);
            end
            checks++;
            if (wrap_b !== (k % 10 == 1)) begin
                errors++; $display("FAIL down_wrap[%0d]: got %b expected %b", k, wrap_b, k % 10 == 1);
            end
            checks++;
            if (tc_b !== (k % 10 == 0)) begin
                errors++; $display("FAIL down_tc[%0d]: got %b expected %b", k, tc_b, k % 10 == 0);
            end
        end
    endtask

    task automatic test_saturate();
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (cnt_c !== 8'((k < 9) ? k : 9)) begin
                errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, cnt_c, (k < 9) ? k : 9);
            end
            checks++;
            if (sat_c !== (k >= 10) || wrap_c !== 1'b0) begin
                errors++; $display("FAIL sat_flag[%0d]: got sat %b wrap %b expected sat %b wrap 0",
                    k, sat_c, wrap_c, k >= 10);
            end
            checks++;
            if (tc_c !== (k >= 9)) begin
                errors++; $display("FAIL sat_tc[%0d]: got %b expected %b", k, tc_c, k >= 9);
            end
        end
        up = 1'b0;
        tick();
        checks++;
        if (cnt_c !== 8'd8 || sat_c !== 1'b0) begin
            errors++; $display("FAIL sat_release: got count %0d sat %b expected count 8 sat 0", cnt_c, sat_c);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (tc_c !== 1'b1) begin
            errors++; $display("FAIL sat_tc_zero: got %b expected 1", tc_c);
        end
        tick();
        checks++;
        if (cnt_c !== 8'd0 || sat_c !== 1'b1 || wrap_c !== 1'b0) begin
            errors++; $display("FAIL sat_low: got count %0d sat %b wrap %b expected count 0 sat 1 wrap 0",
                cnt_c, sat_c, wrap_c);
        end
        en = 1'b0;
        tick();
        checks++;
        if (cnt_c !== 8'd0 || sat_c !== 1'b0) begin
            errors++; $display("FAIL sat_en_off: got count %0d sat %b expected count 0 sat 0", cnt_c, sat_c);
        end
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; load_val = 8'd5; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (cnt_d !== 8'd0 || cnt_a !== 8'd0) begin
            errors++; $display("FAIL prio_clr: got %0d/%0d expected 0/0", cnt_d, cnt_a);
        end
        clr = 1'b0; load_val = 8'd200;
        tick();
        checks++;
        if (cnt_d !== 8'd99) begin
            errors++; $display("FAIL load_clamp: got %0d expected 99", cnt_d);
        end
        checks++;
        if (cnt_a !== 8'd200) begin
            errors++; $display("FAIL load_full: got %0d expected 200", cnt_a);
        end
        load_val = 8'd42;
        tick();
        checks++;
        if (cnt_d !== 8'd42) begin
            errors++; $display("FAIL load_over_en: got %0d expected 42", cnt_d);
        end
        load = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (cnt_d !== 8'd42 || wrap_d !== 1'b0) begin
            errors++; $display("FAIL hold: got count %0d wrap %b expected count 42 wrap 0", cnt_d, wrap_d);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 8'h7E; en = 1'b0;
        tick();
        checks++;
        if (cnt_a !== 8'h7E) begin
            errors++; $display("FAIL areset_preload: got %h expected 7e", cnt_a);
        end
        load = 1'b0; en = 1'b1; up = 1'b1;
        #3 rb = 1'b0;
        #1;
        checks++;
        if (cnt_a !== 8'd0) begin
            errors++; $display("FAIL areset_immediate: got %h expected 0", cnt_a);
        end
        #1 rb = 1'b1;
        tick();
        checks++;
        if (cnt_a !== 8'd1) begin
            errors++; $display("FAIL areset_resume: got %0d expected 1", cnt_a);
        end
        load = 1'b1; load_val = 8'hFF; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (cnt_a !== 8'd0 || wrap_a !== 1'b1) begin
            errors++; $display("FAIL areset_prewrap: got count %0d wrap %b expected count 0 wrap 1", cnt_a, wrap_a);
        end
        en = 1'b0;
        #3 rb = 1'b0;
        #1;
        checks++;
        if (wrap_a !== 1'b0) begin
            errors++; $display("FAIL areset_wrap_abandon: got %b expected 0", wrap_a);
        end
        #1 rb = 1'b1;
        tick();
        checks++;
        if (wrap_a !== 1'b0 || cnt_a !== 8'd0) begin
            errors++; $display("FAIL areset_no_pending: got count %0d wrap %b expected count 0 wrap 0", cnt_a, wrap_a);
        end
    endtask

    task automatic test_alternate();
        load = 1'b1; load_val = 8'h0F; en = 1'b0;
        tick();
        checks++;
        if (cnt_e !== 4'd15) begin
            errors++; $display("FAIL alt_preload: got %0d expected 15", cnt_e);
        end
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            up = (k % 2 == 0);
            #1;
            checks++;
            if (tc_e !== 1'b1) begin
                errors++; $display("FAIL alt_tc[%0d]: got %b expected 1", k, tc_e);
            end
            tick();
            checks++;
            if (cnt_e !== ((k % 2 == 0) ? 4'd0 : 4'd15) || wrap_e !== 1'b1) begin
                errors++; $display("FAIL alt_step[%0d]: got count %0d wrap %b expected count %0d wrap 1",
                    k, cnt_e, wrap_e, (k % 2 == 0) ? 0 : 15);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_priority();
        test_async_reset();
        test_alternate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 255: top of the count range (count runs 0..MAX_VAL), legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on the rising edge.
REQ-005 SHALL have port rb  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port clr  input  1: synchronous clear.
REQ-007 SHALL have port load  input  1: synchronous load of load_val.
REQ-008 SHALL have port load_val  input  WIDTH: load data.
REQ-009 SHALL have port en  input  1: count enable.
REQ-010 SHALL have port up  input  1: direction, 1 = increment, 0 = decrement.
REQ-011 SHALL have port count  output  WIDTH: registered counter value.
REQ-012 SHALL have port tc  output  1: combinational terminal-count flag.
REQ-013 SHALL have port wrap  output  1: registered one-cycle wrap pulse.
REQ-014 SHALL have port sat  output  1: registered flag, high while the counter is held at a range end by saturation.

Function
REQ-015 SHALL apply this per-edge priority: clr, then load, then en, then hold.
REQ-016 SHALL, on clr=1, set count=0, wrap=0 and sat=0, regardless of all other inputs.
REQ-017 SHALL, on load=1 with clr=0, set count=load_val when load_val<=MAX_VAL, else count=MAX_VAL; wrap=0 and sat=0.
REQ-018 SHALL, on en=1 with up=1 and count<MAX_VAL, set count=count+1.
REQ-019 SHALL, on en=1 with up=0 and count>0, set count=count-1.
REQ-020 SHALL, with SATURATE=0, step from MAX_VAL to 0 (up) or from 0 to MAX_VAL (down), and assert wrap for exactly the following cycle.
REQ-021 SHALL, with SATURATE=1, hold count at the range end, keep wrap=0, and set sat=1 for every cycle a step is blocked.
REQ-022 SHALL clear sat on any cycle in which count changes or en=0.
REQ-023 SHALL hold count unchanged when en=0, clr=0 and load=0, with wrap=0.
REQ-024 SHALL drive tc=1 when en=1 and either (up=1 and count==MAX_VAL) or (up=0 and count==0); otherwise tc=0.
REQ-025 SHALL allow a direction change on any cycle, with no extra latency.
REQ-026 SHALL update count one clock after the controlling inputs are sampled; tc has zero latency.
REQ-027 SHALL compute all arithmetic in WIDTH bits with no carry-out port; MAX_VAL=2**WIDTH-1 gives natural binary wrap.
REQ-028 SHALL keep count within 0..MAX_VAL at all times after reset.
REQ-029 SHALL build the incrementer/decrementer from a half-adder carry chain, not a behavioural library adder.

Reset
REQ-030 SHALL, while rb=0, force count=0, wrap=0 and sat=0 immediately, independent of clk.
REQ-031 SHALL resume normal operation on the first rising clk edge after rb rises.
REQ-032 SHALL abandon any in-progress operation (load, wrap or saturation) on reset, with no pending pulse after release.
REQ-033 SHALL drive tc from the current inputs during reset, computed against count=0.

Verification
REQ-034 SHALL be covered by: WIDTH=8, MAX_VAL=255, SATURATE=0, up=1, en=1 for 260 cycles from reset -> count steps 0..255, 0..3; wrap high exactly one cycle after 255->0; tc high while count=255.
REQ-035 SHALL be covered by: MAX_VAL=9, SATURATE=0, up=0, en=1 from 0 -> count 9,8,...; wrap pulse after 0->9; tc high at count=0.
REQ-036 SHALL be covered by: MAX_VAL=9, SATURATE=1, up=1, en=1 for 12 cycles -> count holds 9; sat=1 from the first blocked step; wrap never asserts; up=0 then gives 8 and sat=0.
REQ-037 SHALL be covered by: clr=1, load=1, load_val=5, en=1 on the same edge -> count=0; then load=1, load_val=200 with MAX_VAL=99 -> count=99.
REQ-038 SHALL be covered by: rb pulsed low mid-clock while count=0x7E, en=1 -> count=0 asynchronously, before the next edge; first post-release increment gives 1.
REQ-039 SHALL be covered by: WIDTH=4, MAX_VAL=15, alternating up each cycle with en=1 from count=15 -> count 0,15,0,...; wrap asserts after every transition.
